contador_multi: RTL

- Parametrised successor to the per-FIFO push counters in the transaction layer.
- Keeps one up/down occupancy-or-event counter per channel and supports single-channel reads on request.
- Adds a snapshot "dump" mode that streams every channel's count on consecutive cycles.
- Sits beside the FIFO bank; it is read by the test/status logic.

---
 rtl/contador_multi_pkg.sv | 22 ++
 rtl/contador_multi_if.sv | 41 ++++
 rtl/contador_multi_canal.sv | 59 +++++
 rtl/contador_multi.sv | 108 ++++++++++
 4 files changed

// File: rtl/contador_multi_pkg.sv
// Shared types and helpers for the multi-channel counter block.
// Saturating step helper works on a fixed 16-bit carrier, so CW may be at most 16.
package contador_pkg;

    typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_e;

    localparam int NCH_D    = 5;
    localparam int CW_D     = 5;
    localparam int CNT_MAXW = 16;

    function automatic logic [CNT_MAXW-1:0] sat_step(input logic [CNT_MAXW-1:0] v,
                                                     input logic [CNT_MAXW-1:0] maxv,
                                                     input logic inc,
                                                     input logic dec);
        logic [CNT_MAXW-1:0] r;
        r = v;
        if (inc && (v != maxv))    r = v + 1'b1;
        else if (dec && (v != '0)) r = v - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/contador_multi_if.sv
// Control/status bundle for contador_multi; sat exists only with CONTADOR_SAT_FLAG_EN.
interface contador_multi_if
    import contador_pkg::*;
#(
    parameter int NCH = NCH_D,
    parameter int CW  = CW_D,
    parameter int IW  = 3
);
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           clr;
    logic           req;
    logic [IW-1:0]  idx;
    logic           dump;
    logic [CW-1:0]  data;
    logic [IW-1:0]  data_idx;
    logic           valid;
    logic           last;
    logic           err;
    logic           busy;
`ifdef CONTADOR_SAT_FLAG_EN
    logic [NCH-1:0] sat;
`endif

    modport master (
        output push, pop, clr, req, idx, dump,
        input  data, data_idx, valid, last, err, busy
`ifdef CONTADOR_SAT_FLAG_EN
        , input sat
`endif
    );

    modport slave (
        input  push, pop, clr, req, idx, dump,
        output data, data_idx, valid, last, err, busy
`ifdef CONTADOR_SAT_FLAG_EN
        , output sat
`endif
    );

endinterface

// File: rtl/contador_multi_canal.sv
// One saturating channel counter; sticky saturation flag under CONTADOR_SAT_FLAG_EN.
module contador_canal
    import contador_pkg::*;
#(
    parameter int CW        = CW_D,
    parameter int DOWN_EN_P = 0
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o
`ifdef CONTADOR_SAT_FLAG_EN
    , output logic        sat_o
`endif
);

    localparam bit DN = (DOWN_EN_P != 0);
    localparam logic [CNT_MAXW-1:0] MAXV = CNT_MAXW'((32'd1 << CW) - 32'd1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          inc, dec;

    // Simultaneous push and pop cancel only when pop is honoured.
    assign inc = push_i & ~(DN & pop_i);
    assign dec = DN & pop_i & ~push_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) cnt_d = '0;
        else       cnt_d = CW'(sat_step(CNT_MAXW'(cnt_q), MAXV, inc, dec));
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

`ifdef CONTADOR_SAT_FLAG_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (clr_i) sat_d = 1'b0;
        else if ((inc && (CNT_MAXW'(cnt_q) == MAXV)) || (dec && (cnt_q == '0))) sat_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) sat_q <= 1'b0;
        else          sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`endif

endmodule

// File: rtl/contador_multi.sv
// Multi-channel push/occupancy counters with single reads and snapshot dump.
// Optional CONTADOR_SAT_FLAG_EN adds sticky per-channel saturation flags folded into err.
module contador_multi
    import contador_pkg::*;
#(
    parameter int NCH       = NCH_D,
    parameter int CW        = CW_D,
    parameter int IW        = 3,
    parameter int DOWN_EN_P = 0
) (
    input  logic            clk,
    input  logic            reset_L,
    contador_multi_if.slave bus
);

    logic [NCH-1:0][CW-1:0] cnt;
    logic [NCH-1:0][CW-1:0] snap_q;
    logic [IW-1:0]          ptr_q;
    state_e                 state_q;
    logic [CW-1:0]          data_q;
    logic [IW-1:0]          idx_q;
    logic                   valid_q, last_q, err_q, busy_q;
    logic                   in_rng, sat_idx, sat_ptr;

`ifdef CONTADOR_SAT_FLAG_EN
    logic [NCH-1:0] sat;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        contador_canal #(.CW(CW), .DOWN_EN_P(DOWN_EN_P)) u_canal (
            .clk    (clk),
            .reset_L(reset_L),
            .push_i (bus.push[c]),
            .pop_i  (bus.pop[c]),
            .clr_i  (bus.clr),
            .cnt_o  (cnt[c])
`ifdef CONTADOR_SAT_FLAG_EN
            , .sat_o(sat[c])
`endif
        );
    end

    assign in_rng = (32'(bus.idx) < NCH);

`ifdef CONTADOR_SAT_FLAG_EN
    assign sat_idx = in_rng & sat[bus.idx];
    assign sat_ptr = sat[ptr_q];
    assign bus.sat = sat;
`else
    assign sat_idx = 1'b0;
    assign sat_ptr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.dump) begin
                        snap_q  <= cnt;
                        ptr_q   <= '0;
                        state_q <= DUMP;
                        busy_q  <= 1'b1;
                    end else if (bus.req) begin
                        valid_q <= 1'b1;
                        idx_q   <= bus.idx;
                        data_q  <= in_rng ? cnt[bus.idx] : '0;
                        err_q   <= ~in_rng | sat_idx;
                    end
                end
                DUMP: begin
                    // Snapshot is frozen; live counters and clr proceed independently.
                    valid_q <= 1'b1;
                    data_q  <= snap_q[ptr_q];
                    idx_q   <= ptr_q;
                    err_q   <= sat_ptr;
                    ptr_q   <= ptr_q + 1'b1;
                    if (ptr_q == IW'(NCH - 1)) begin
                        last_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data     = data_q;
    assign bus.data_idx = idx_q;
    assign bus.valid    = valid_q;
    assign bus.last     = last_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;

endmodule
